// File: rtl/aes_ingress_queue.sv
// Word-serial AES key/plaintext assembler with a DEPTH-entry plaintext queue and engine start handshake.
// Optional completed-block counter enabled by defining AES_INGRESS_STATS_EN.
module aes_ingress_queue #(
  parameter int DIN_W = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_,
  input  logic [DIN_W-1:0]           din,
  input  logic [1:0]                 cmd,
  input  logic                       transformer_done,
  output logic                       ready,
  output logic                       cmd_err,
  output logic [127:0]               key_out,
  output logic                       key_valid,
  output logic [127:0]               plain_out,
  output logic                       engine_start,
  output logic [$clog2(DEPTH):0]     level,
  output logic [15:0]                blk_count
);

  localparam int WPB = 128 / DIN_W;
  localparam int CW  = (WPB > 1) ? $clog2(WPB) : 1;
  localparam int PW  = $clog2(DEPTH);
  localparam int LW  = PW + 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state;
  logic [CW-1:0]   wcnt;
  logic            part_pt;
  logic [127:0]    asm_q;
  logic [127:0]    mem [DEPTH];
  logic [PW-1:0]   wp, rp;

  logic            is_word, is_pt, is_abort, allowed, accept, mismatch, last, push, pop;
  logic [CW-1:0]   slot;
  logic [6:0]      idx;
  logic [127:0]    blk;
  logic [LW-1:0]   level_nxt;

  always_comb begin
    is_word  = (cmd == 2'b01) || (cmd == 2'b10);
    is_pt    = (cmd == 2'b10);
    is_abort = (cmd == 2'b11);
    allowed  = is_pt ? ready : ((state == IDLE) && (level == '0));
    accept   = is_word && allowed;
    // An accepted word of the other type throws away the partial and restarts at word 0
    mismatch = accept && (wcnt != '0) && (part_pt != is_pt);
    slot     = mismatch ? '0 : wcnt;
    last     = accept && (slot == CW'(WPB - 1));
    idx      = 7'((WPB - 1 - int'(slot)) * DIN_W);
    blk      = asm_q;
    blk[idx +: DIN_W] = din;
    push     = last && is_pt;
    pop      = (state == BUSY) && transformer_done && !is_abort;
    level_nxt = level + LW'(push) - LW'(pop);
  end

  assign plain_out = mem[rp];

  always_ff @(posedge clk) begin
    if (rst_) begin
      state        <= IDLE;
      wcnt         <= '0;
      part_pt      <= 1'b0;
      asm_q        <= '0;
      wp           <= '0;
      rp           <= '0;
      level        <= '0;
      ready        <= 1'b0;
      cmd_err      <= 1'b0;
      key_out      <= '0;
      key_valid    <= 1'b0;
      engine_start <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      cmd_err      <= is_word && (!allowed || mismatch);
      engine_start <= 1'b0;
      if (is_abort) begin
        // Key survives abort; everything queued or half-assembled is dropped
        wcnt  <= '0;
        wp    <= '0;
        rp    <= '0;
        level <= '0;
        ready <= 1'b1;
        state <= IDLE;
      end else begin
        if (accept) begin
          asm_q   <= blk;
          part_pt <= is_pt;
          wcnt    <= last ? '0 : slot + 1'b1;
        end
        if (last && !is_pt) begin
          key_out   <= blk;
          key_valid <= 1'b1;
        end
        if (push) begin
          mem[wp] <= blk;
          wp      <= wp + 1'b1;
        end
        if (pop) rp <= rp + 1'b1;
        level <= level_nxt;
        ready <= (level_nxt != LW'(DEPTH));
        case (state)
          IDLE: if ((level != '0) && key_valid) begin
            state        <= BUSY;
            engine_start <= 1'b1;
          end
          BUSY: if (pop) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef AES_INGRESS_STATS_EN
  always_ff @(posedge clk) begin
    if (rst_)     blk_count <= '0;
    else if (pop) blk_count <= blk_count + 16'd1;
  end
`else
  assign blk_count = '0;
`endif

endmodule
